// File: rtl/pipe_stall_ctrl_if.sv
// Hazard, mult/div and MEM-wait signals exchanged between the pipeline and
// its stall controller; the controller sits on the slave side.
interface pipe_stall_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_is_load;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic        ex_md_start;
  logic        ex_md_is_div;
  logic        mem_stallreq;
  logic [5:0]  stall;
  logic        md_busy;
  logic        md_done;
  logic        load_use;
  logic [31:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_is_load, ex_rf_we, ex_rf_waddr,
           ex_md_start, ex_md_is_div, mem_stallreq,
    input  stall, md_busy, md_done, load_use, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
           ex_is_load, ex_rf_we, ex_rf_waddr,
           ex_md_start, ex_md_is_div, mem_stallreq,
    output stall, md_busy, md_done, load_use, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall arbiter: MEM wait > mult/div occupancy > load-use, with a
// mult/div occupancy FSM and a saturating stalled-cycle counter.
module pipe_stall_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int MUL_CYCLES = 3,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_stall_ctrl_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, MD_RUN, MD_DONE} state_t;

  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             hazard;
  logic [5:0]       stall;
  logic [31:0]      stall_cycles;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Register $0 is hardwired to zero and can never carry a hazard.
  always_comb begin
    hazard = bus.ex_is_load & bus.ex_rf_we & (bus.ex_rf_waddr != 5'd0) &
             ((bus.id_uses_rs & (bus.id_rs == bus.ex_rf_waddr)) |
              (bus.id_uses_rt & (bus.id_rt == bus.ex_rf_waddr)));
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.ex_md_start && !bus.mem_stallreq) begin
          state_nxt = MD_RUN;
          cnt_nxt   = bus.ex_md_is_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      MD_RUN: begin
        if (cnt == '0) state_nxt = MD_DONE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      MD_DONE: begin
        if (!bus.mem_stallreq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (bus.mem_stallreq)
      stall = 6'b011111;
    else if (((state == IDLE) && bus.ex_md_start) || (state == MD_RUN))
      stall = 6'b001111;
    else if (hazard)
      stall = 6'b000111;
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    cnt   <= cnt_nxt;
    if (rst)
      stall_cycles <= '0;
    else if (stall[0])
      stall_cycles <= sat_inc(stall_cycles);
  end

  assign bus.stall        = stall;
  assign bus.stall_cycles = stall_cycles;
  assign bus.md_busy      = ~rst & (state == MD_RUN);
  assign bus.md_done      = ~rst & (state == MD_DONE);
  assign bus.load_use     = ~rst & hazard;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with default parameters (divide 33, multiply 3).
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl_if bif ();

  pipe_stall_ctrl #(.DIV_CYCLES(33), .MUL_CYCLES(3), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.id_rs        = 5'd0;
    bif.id_rt        = 5'd0;
    bif.id_uses_rs   = 1'b0;
    bif.id_uses_rt   = 1'b0;
    bif.ex_is_load   = 1'b0;
    bif.ex_rf_we     = 1'b0;
    bif.ex_rf_waddr  = 5'd0;
    bif.ex_md_start  = 1'b0;
    bif.ex_md_is_div = 1'b0;
    bif.mem_stallreq = 1'b0;
  endtask

  initial begin
    // Reset
    rst = 1'b1;
    clear_inputs();
    advance();
    sample();
    chk("rst_stall", {26'd0, bif.stall}, 32'h00);
    chk("rst_busy", {31'd0, bif.md_busy}, 32'd0);
    chk("rst_done", {31'd0, bif.md_done}, 32'd0);
    advance();
    sample();
    chk("rst_cycles", bif.stall_cycles, 32'd0);
    rst = 1'b0;
    advance();

    // Load-use through rs
    bif.ex_is_load = 1'b1; bif.ex_rf_we = 1'b1; bif.ex_rf_waddr = 5'd5;
    bif.id_rs = 5'd5; bif.id_uses_rs = 1'b1;
    sample();
    chk("lu_rs_flag", {31'd0, bif.load_use}, 32'd1);
    chk("lu_rs_stall", {26'd0, bif.stall}, 32'h07);
    advance();
    // Register $0 never hazards
    bif.ex_rf_waddr = 5'd0; bif.id_rs = 5'd0;
    sample();
    chk("lu_cnt1", bif.stall_cycles, 32'd1);
    chk("lu_r0_flag", {31'd0, bif.load_use}, 32'd0);
    chk("lu_r0_stall", {26'd0, bif.stall}, 32'h00);
    advance();
    // Load-use through rt
    bif.id_uses_rs = 1'b0; bif.id_uses_rt = 1'b1; bif.id_rt = 5'd9; bif.ex_rf_waddr = 5'd9;
    sample();
    chk("lu_rt_flag", {31'd0, bif.load_use}, 32'd1);
    chk("lu_rt_stall", {26'd0, bif.stall}, 32'h07);
    advance();
    // Same registers but EX is not a load
    bif.ex_is_load = 1'b0;
    sample();
    chk("lu_noload", {31'd0, bif.load_use}, 32'd0);
    chk("lu_cnt2", bif.stall_cycles, 32'd2);
    advance();
    clear_inputs();

    // Divide: start cycle, 32 MD_RUN cycles, then one MD_DONE cycle
    bif.ex_md_start = 1'b1; bif.ex_md_is_div = 1'b1;
    sample();
    chk("div_start_stall", {26'd0, bif.stall}, 32'h0F);
    chk("div_start_busy", {31'd0, bif.md_busy}, 32'd0);
    advance();
    for (int i = 0; i < 32; i++) begin
      sample();
      chk($sformatf("div_run%0d_stall", i), {26'd0, bif.stall}, 32'h0F);
      chk($sformatf("div_run%0d_busy", i), {30'd0, bif.md_busy, bif.md_done}, 32'd2);
      advance();
    end
    bif.ex_md_start = 1'b0;
    sample();
    chk("div_done", {31'd0, bif.md_done}, 32'd1);
    chk("div_done_stall", {26'd0, bif.stall}, 32'h00);
    chk("div_done_busy", {31'd0, bif.md_busy}, 32'd0);
    advance();
    sample();
    chk("div_idle_done", {31'd0, bif.md_done}, 32'd0);
    chk("div_cnt", bif.stall_cycles, 32'd35);
    advance();

    // Multiply started together with a load-use hazard, then held by MEM wait
    bif.ex_md_start = 1'b1; bif.ex_md_is_div = 1'b0;
    bif.ex_is_load = 1'b1; bif.ex_rf_we = 1'b1; bif.ex_rf_waddr = 5'd3;
    bif.id_rs = 5'd3; bif.id_uses_rs = 1'b1;
    sample();
    chk("mul_lu_stall", {26'd0, bif.stall}, 32'h0F);
    chk("mul_lu_flag", {31'd0, bif.load_use}, 32'd1);
    advance();
    bif.ex_is_load = 1'b0; bif.mem_stallreq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("mul_run%0d_stall", i), {26'd0, bif.stall}, 32'h1F);
      chk($sformatf("mul_run%0d_busy", i), {31'd0, bif.md_busy}, 32'd1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("mul_hold%0d_done", i), {31'd0, bif.md_done}, 32'd1);
      chk($sformatf("mul_hold%0d_stall", i), {26'd0, bif.stall}, 32'h1F);
      advance();
    end
    bif.mem_stallreq = 1'b0; bif.ex_md_start = 1'b0;
    sample();
    chk("mul_rel_done", {31'd0, bif.md_done}, 32'd1);
    chk("mul_rel_stall", {26'd0, bif.stall}, 32'h00);
    advance();
    sample();
    chk("mul_idle_done", {31'd0, bif.md_done}, 32'd0);
    chk("mul_cnt", bif.stall_cycles, 32'd41);
    advance();
    clear_inputs();

    // Start blocked by MEM wait
    bif.ex_md_start = 1'b1; bif.mem_stallreq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("blk%0d_stall", i), {26'd0, bif.stall}, 32'h1F);
      chk($sformatf("blk%0d_busy", i), {31'd0, bif.md_busy}, 32'd0);
      advance();
    end
    bif.mem_stallreq = 1'b0;
    sample();
    chk("blk_start_stall", {26'd0, bif.stall}, 32'h0F);
    advance();
    sample();
    chk("blk_run_busy", {31'd0, bif.md_busy}, 32'd1);
    advance();
    sample();
    chk("blk_run2_busy", {31'd0, bif.md_busy}, 32'd1);
    advance();
    bif.ex_md_start = 1'b0;
    sample();
    chk("blk_done", {31'd0, bif.md_done}, 32'd1);
    chk("blk_cnt", bif.stall_cycles, 32'd46);
    advance();

    // Reset in cycle 10 of a divide
    bif.ex_md_start = 1'b1; bif.ex_md_is_div = 1'b1;
    for (int i = 0; i < 9; i++) advance();
    sample();
    chk("abort_busy_pre", {31'd0, bif.md_busy}, 32'd1);
    rst = 1'b1;
    sample();
    chk("abort_busy_rst", {31'd0, bif.md_busy}, 32'd0);
    advance();
    rst = 1'b0; bif.ex_md_start = 1'b0;
    sample();
    chk("abort_cnt", bif.stall_cycles, 32'd0);
    chk("abort_stall", {26'd0, bif.stall}, 32'h00);
    chk("abort_busy", {31'd0, bif.md_busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      sample();
      chk($sformatf("abort_nodone%0d", i), {31'd0, bif.md_done}, 32'd0);
      advance();
    end
    chk("abort_cnt_end", bif.stall_cycles, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
